cu_pe_lookup_ctrl: RTL and testbench

//  Command sequencer for the BRAM->CU->TCAM->PE lookup datapath.
//  - Accepts write (program a BRAM row) and search (read rows at a base address) commands over valid/ready.
//  - Drives the shared BRAM port (ena/wea/addr/din).
//  - Waits out the fixed CU/TCAM/PE pipeline latency, then captures the priority-encoder index.
//  - Returns the index on a valid/ready response channel.
//  - Sits between the host/test driver and the lookup datapath top.

---
 rtl/cu_pe_pkg.sv | 27 ++
 rtl/cu_pe_lookup_ctrl_if.sv | 47 ++++
 rtl/lat_cnt.sv | 37 +++
 rtl/cu_pe_lookup_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cu_pe_lookup_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cu_pe_pkg.sv
// Shared definitions for the BRAM->CU->TCAM->PE lookup controller.
// Holds the FSM state encoding, the datapath width defaults, the pipeline
// latency default and a saturating-increment helper for the stats counters.
package cu_pe_pkg;

    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned DATA_W       = 36;
    localparam int unsigned IDX_W        = 8;
    localparam int unsigned PIPE_LAT_DEF = 3;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/cu_pe_lookup_ctrl_if.sv
// Bus bundle between the host/datapath side and cu_pe_lookup_ctrl.
// Carries: command channel (cmd_*), shared BRAM port (bram_*), priority
// encoder result (pe_*), response channel (rsp_*) and busy.
// With CU_PE_LOOKUP_STATS_EN defined it also carries hit_cnt/miss_cnt.
// master: host/datapath side; slave: the controller.
interface cu_pe_lookup_ctrl_if;

    logic                           cmd_valid;
    logic                           cmd_ready;
    logic                           cmd_wr;
    logic [cu_pe_pkg::ADDR_W-1:0]   cmd_addr;
    logic [cu_pe_pkg::DATA_W-1:0]   cmd_data;
    logic                           bram_ena;
    logic                           bram_wea;
    logic [cu_pe_pkg::ADDR_W-1:0]   bram_addr;
    logic [cu_pe_pkg::DATA_W-1:0]   bram_din;
    logic [cu_pe_pkg::IDX_W-1:0]    pe_idx;
    logic                           pe_valid;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [cu_pe_pkg::IDX_W-1:0]    rsp_idx;
    logic                           rsp_hit;
    logic                           busy;
`ifdef CU_PE_LOOKUP_STATS_EN
    logic [cu_pe_pkg::STAT_W-1:0]   hit_cnt;
    logic [cu_pe_pkg::STAT_W-1:0]   miss_cnt;
`endif

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, pe_idx, pe_valid, rsp_ready,
        input  cmd_ready, bram_ena, bram_wea, bram_addr, bram_din,
        input  rsp_valid, rsp_idx, rsp_hit, busy
`ifdef CU_PE_LOOKUP_STATS_EN
        , input hit_cnt, miss_cnt
`endif
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, pe_idx, pe_valid, rsp_ready,
        output cmd_ready, bram_ena, bram_wea, bram_addr, bram_din,
        output rsp_valid, rsp_idx, rsp_hit, busy
`ifdef CU_PE_LOOKUP_STATS_EN
        , output hit_cnt, miss_cnt
`endif
    );

endinterface

// File: rtl/lat_cnt.sv
// Loadable 4-bit down-counter used to wait out the CU/TCAM/PE pipeline.
// Ports: clk, rst (sync, active-high), load/load_val (load has priority),
// dec (decrement, ignored at zero), cnt_zero_c (combinational zero flag).
module lat_cnt
    import cu_pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             cnt_zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero_c = (cnt_q == '0);

endmodule

// File: rtl/cu_pe_lookup_ctrl.sv
// Command sequencer for the BRAM->CU->TCAM->PE lookup datapath.
// Accepts write/search commands, drives the shared BRAM port, waits
// PIPE_LAT cycles after the read, captures the priority-encoder result and
// returns it on the response channel. All bus outputs are registered and
// reflect the state being entered, so each state's outputs appear in it.
// Ports: clk, rst (sync, active-high), bus (cu_pe_lookup_ctrl_if.slave).
// Optional: CU_PE_LOOKUP_STATS_EN adds saturating hit/miss counters.
module cu_pe_lookup_ctrl
    import cu_pe_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cu_pe_lookup_ctrl_if.slave   bus
);

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                bram_ena_q, bram_ena_d;
    logic                bram_wea_q, bram_wea_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_din_q, bram_din_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero_c;

    // WAIT lasts PIPE_LAT cycles: load PIPE_LAT-1, leave once zero is seen.
    lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_val   (CNT_W'(PIPE_LAT - 1)),
        .dec        (cnt_dec),
        .cnt_zero_c (cnt_zero_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        bram_ena_d  = 1'b0;
        bram_wea_d  = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_hit_d   = rsp_hit_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    bram_addr_d = bus.cmd_addr;
                    bram_ena_d  = 1'b1;
                    if (bus.cmd_wr) begin
                        bram_din_d = bus.cmd_data;
                        bram_wea_d = 1'b1;
                        state_d    = S_WRITE;
                    end else begin
                        state_d    = S_READ;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                cnt_load = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_zero_c) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_CAPT: begin
                rsp_hit_d = bus.pe_valid;
                rsp_idx_d = bus.pe_valid ? bus.pe_idx : '0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            bram_ena_q  <= 1'b0;
            bram_wea_q  <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            bram_ena_q  <= bram_ena_d;
            bram_wea_q  <= bram_wea_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.bram_ena  = bram_ena_q;
    assign bus.bram_wea  = bram_wea_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_hit   = rsp_hit_q;

`ifdef CU_PE_LOOKUP_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    // One count per capture, steered by the match flag.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_CAPT) begin
            if (bus.pe_valid) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cu_pe_lookup_ctrl.sv
// Self-checking bench for cu_pe_lookup_ctrl: reset state, write, hit and
// miss searches, stalled response, reset abort, and (when
// CU_PE_LOOKUP_STATS_EN is defined) the hit/miss counters. Expected search
// results are queued when a search is issued and popped on the response
// handshake.
module tb_cu_pe_lookup_ctrl;

    localparam int unsigned PIPE_LAT = 3;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [8:0] exp_q[$];

    cu_pe_lookup_ctrl_if bus ();

    cu_pe_lookup_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue a search at a negedge; optionally stall the response or abort
    // with a reset during WAIT. Returns at a negedge with the bus idle.
    task automatic do_search(input logic [1:0] base, input logic pv,
                             input logic [7:0] pidx, input int stall,
                             input bit abort);
        int          off;
        logic [7:0]  held_idx;
        logic [8:0]  exp;
        bus.pe_valid  = pv;
        bus.pe_idx    = pidx;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = base;
        bus.cmd_data  = 36'($urandom);
        bus.rsp_ready = (stall == 0);
        if (!abort) exp_q.push_back({pv, pv ? pidx : 8'h00});
        check("srch_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("rd_ena", bus.bram_ena, 1);
        check("rd_wea", bus.bram_wea, 0);
        check("rd_addr", bus.bram_addr, base);
        off = 0;
        while (!bus.rsp_valid && off < 40) begin
            if (abort && off == 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", bus.busy, 0);
                check("abort_cmd_ready", bus.cmd_ready, 1);
                check("abort_ena", bus.bram_ena, 0);
                for (int i = 0; i < 15; i++) begin
                    check("abort_no_rsp", bus.rsp_valid, 0);
                    @(negedge clk);
                end
                return;
            end
            @(negedge clk);
            off++;
        end
        check("srch_latency", 64'(off), 64'(PIPE_LAT + 2));
        check("rsp_busy", bus.busy, 1);
        if (stall > 0) begin
            held_idx      = bus.rsp_idx;
            bus.cmd_valid = 1'b1;
            bus.cmd_wr    = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", bus.rsp_valid, 1);
                check("stall_idx", bus.rsp_idx, held_idx);
                check("stall_cmd_ready", bus.cmd_ready, 0);
                check("stall_ena", bus.bram_ena, 0);
            end
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                exp = exp_q.pop_front();
                check("rsp_hit", bus.rsp_hit, exp[8]);
                check("rsp_idx", bus.rsp_idx, exp[7:0]);
            end
        end else begin
            check("rsp_seen", 0, 1);
        end
        @(negedge clk);
        check("rsp_drop", bus.rsp_valid, 0);
        check("post_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.pe_idx    = '0;
        bus.pe_valid  = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ena", bus.bram_ena, 0);
        check("rst_wea", bus.bram_wea, 0);
`ifdef CU_PE_LOOKUP_STATS_EN
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_miss_cnt", bus.miss_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Write row 2.
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = 2'd2;
        bus.cmd_data  = 36'h0_0000_00AB;
        check("wr_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("wr_ena", bus.bram_ena, 1);
        check("wr_wea", bus.bram_wea, 1);
        check("wr_addr", bus.bram_addr, 2);
        check("wr_din", bus.bram_din, 36'hAB);
        check("wr_cmd_ready_lo", bus.cmd_ready, 0);
        @(negedge clk);
        check("wr_ena_once", bus.bram_ena, 0);
        check("wr_cmd_ready_back", bus.cmd_ready, 1);
        check("wr_din_hold", bus.bram_din, 36'hAB);

        // Hit, miss, stalled response.
        do_search(2'd1, 1'b1, 8'd37, 0, 1'b0);
        do_search(2'd3, 1'b0, 8'hFF, 0, 1'b0);
        do_search(2'd0, 1'b1, 8'd90, 10, 1'b0);

        // Reset during WAIT.
        do_search(2'd2, 1'b1, 8'd5, 0, 1'b1);

        // Counter scenario: 3 hits, 2 misses after the reset above.
        do_search(2'd0, 1'b1, 8'd1, 0, 1'b0);
        do_search(2'd1, 1'b0, 8'd2, 0, 1'b0);
        do_search(2'd2, 1'b1, 8'd3, 2, 1'b0);
        do_search(2'd3, 1'b0, 8'hA5, 0, 1'b0);
        do_search(2'd3, 1'b1, 8'd200, 0, 1'b0);
`ifdef CU_PE_LOOKUP_STATS_EN
        check("hit_cnt", bus.hit_cnt, 3);
        check("miss_cnt", bus.miss_cnt, 2);
`endif
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
